// File: rtl/dpram_stream_reader.sv
// rtl/dpram_stream_reader.sv - read sequencer turning a simple_dpram_sclk range into a valid/ready stream
// The RAM output register acts as a third, pass-through buffer slot so the first word streams one cycle after its read.
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_inflight;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;

  logic                  w_pop;
  logic [1:0]            w_level;
  logic                  w_buf_push;
  logic                  w_buf_pop;
  logic [DATA_WIDTH-1:0] w_head;

  // Words held after this cycle: stored entries plus the returning read, minus the beat leaving now.
  assign w_pop   = m_valid & m_ready;
  assign w_level = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

  assign ram_re    = (r_state == S_READ) & (r_rem != '0) & (w_level < 2'd2) & ~abort;
  assign ram_raddr = r_addr;

  assign m_valid = (r_count != 2'd0) | r_inflight;
  assign w_head  = r_rd_ptr ? r_buf1 : r_buf0;
  assign m_data  = ((r_count == 2'd0) && r_inflight) ? ram_dout : w_head;

  // A returning word consumed directly from the RAM output never enters storage.
  assign w_buf_push = r_inflight & ~(w_pop & (r_count == 2'd0));
  assign w_buf_pop  = w_pop & (r_count != 2'd0);

  assign busy = (r_state == S_READ);
  assign done = (r_state == S_DONE);

  // Zero-length transfers pass through READ so busy is visible for one cycle before done.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = S_READ;
        S_READ: if ((r_rem == '0) && (w_level == 2'd0)) w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && start && !abort) begin
        r_addr <= base_addr;
        r_rem  <= length;
      end else if (ram_re) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end

      if (abort) begin
        r_inflight <= 1'b0;
        r_count    <= 2'd0;
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
      end else begin
        r_inflight <= ram_re;
        r_count    <= w_level;
        if (w_buf_push) begin
          if (r_wr_ptr) r_buf1 <= ram_dout;
          else          r_buf0 <= ram_dout;
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_buf_pop) r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb/tb_dpram_stream_reader.sv - self-checking bench for dpram_stream_reader
// Transfers come from a vector table; expected words are read from the RAM image by address.
module tb_dpram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, done, ram_re, m_valid;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int failures = 0;

  dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .ram_raddr(ram_raddr), .ram_re(ram_re),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_re) ram_dout <= mem[ram_raddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            mode;        // 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
    int            abort_after; // beats before abort, -1 for none
    bit            poke;        // pulse start mid-transfer with another base
    int            exp_beats;
    bit            exp_done;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    logic [DW-1:0] expq[$];
    logic [AW-1:0] a;
    logic [DW-1:0] prev_data = '0;
    bit            prev_stall = 0;
    bit            busy_ok = 1;
    bit            order_ok = 1;
    bit            rule_ok = 1;
    bit            hold_ok = 1;
    int            issued = 0, beats = 0, first_valid = -1, done_cyc = -1, abort_cyc = -1;
    int            budget;
    bit            pop;
    budget = v.len * 8 + 30;
    for (int i = 0; i < v.len; i++) begin
      a = v.base + AW'(i);
      expq.push_back(mem[a]);
    end
    @(negedge clk);
    start = 1'b1; base_addr = v.base; length = LW'(v.len); m_ready = 1'b0; abort = 1'b0;
    for (int c = 1; c < budget; c++) begin
      @(negedge clk);
      start = v.poke && (c == 3);
      base_addr = (v.poke && c == 3) ? '0 : v.base;
      abort = (v.abort_after >= 0) && (abort_cyc < 0) && (beats == v.abort_after);
      case (v.mode)
        0: m_ready = 1'b1;
        1: m_ready = ((c - 1) % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort) m_ready = 1'b0;
      #1;
      if (abort_cyc >= 0) begin
        if (c == abort_cyc + 1) begin
          check("abort_valid_drop", m_valid, 0);
          check("abort_busy_drop", busy, 0);
        end
        if (done) done_cyc = c;
        if (m_valid || ram_re) rule_ok = 0;
        if (c >= abort_cyc + 5) break;
        continue;
      end
      pop = m_valid & m_ready;
      if (ram_re) begin
        a = v.base + AW'(issued);
        if (ram_raddr !== a) order_ok = 0;
        if ((issued - beats - int'(pop)) >= 2) rule_ok = 0;
        issued++;
      end
      if ((issued - beats) > 3) rule_ok = 0;
      if (prev_stall && m_data !== prev_data) hold_ok = 0;
      if (m_valid && first_valid < 0) first_valid = c;
      if (pop) begin
        if (expq.size() == 0) order_ok = 0;
        else if (m_data !== expq.pop_front()) order_ok = 0;
        beats++;
      end
      if (abort) abort_cyc = c;
      if (done) begin
        done_cyc = c;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
      prev_stall = m_valid & ~m_ready;
      prev_data = m_data;
    end
    check("beats", 64'(beats), 64'(v.exp_beats));
    check("data_and_addr_order", order_ok, 1);
    check("issue_rule_no_overflow", rule_ok, 1);
    check("stall_hold", hold_ok, 1);
    if (v.exp_done) begin
      check("done_seen", done_cyc >= 0, 1);
      check("busy_until_done", busy_ok, 1);
      check("reads_issued", 64'(issued), 64'(v.len));
      if (v.mode == 0) begin
        check("done_cycle", 64'(done_cyc), 64'(v.len + 2));
        check("first_valid_cycle", 64'(first_valid), 64'(v.len == 0 ? -1 : 2));
      end
      @(negedge clk); #1;
      check("done_one_cycle", {done, busy}, 2'b00);
    end else begin
      check("no_done_after_abort", done_cyc, -1);
    end
    abort = 1'b0; start = 1'b0; m_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    vecs.push_back('{base: 11'h010, len: 4,  mode: 0, abort_after: -1, poke: 0, exp_beats: 4,  exp_done: 1});
    vecs.push_back('{base: 11'h7FE, len: 4,  mode: 0, abort_after: -1, poke: 0, exp_beats: 4,  exp_done: 1});
    vecs.push_back('{base: 11'h100, len: 8,  mode: 1, abort_after: -1, poke: 1, exp_beats: 8,  exp_done: 1});
    vecs.push_back('{base: 11'h200, len: 0,  mode: 0, abort_after: -1, poke: 0, exp_beats: 0,  exp_done: 1});
    vecs.push_back('{base: 11'h300, len: 16, mode: 0, abort_after: 5,  poke: 0, exp_beats: 5,  exp_done: 0});
    vecs.push_back('{base: 11'h040, len: 6,  mode: 0, abort_after: -1, poke: 0, exp_beats: 6,  exp_done: 1});
    vecs.push_back('{base: 11'h7F0, len: 20, mode: 2, abort_after: -1, poke: 0, exp_beats: 20, exp_done: 1});
    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r.base = AW'($urandom_range(0, DEPTH - 1));
      r.len = int'($urandom_range(1, 40));
      r.mode = 2;
      r.abort_after = -1;
      r.poke = 0;
      r.exp_beats = r.len;
      r.exp_done = 1;
      vecs.push_back(r);
    end

    #1;
    check("reset_outputs", {busy, done, ram_re, ram_raddr, m_valid, m_data}, '0);
    #22 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_xfer(vecs[i]);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 11'h123; length = LW'(4);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; #1;
    check("abort_beats_start_busy", busy, 0);
    @(negedge clk); #1;
    check("abort_beats_start_re", {busy, ram_re, m_valid}, 3'b000);

    // asynchronous reset in the middle of a transfer
    @(negedge clk);
    start = 1'b1; base_addr = 11'h050; length = LW'(10); m_ready = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {busy, done, ram_re, ram_raddr, m_valid, m_data}, '0);
    #16 rst_n = 1'b1;
    m_ready = 1'b0;
    #1 check("idle_after_reset", {busy, done, m_valid}, 3'b000);
    run_xfer('{base: 11'h0A0, len: 5, mode: 0, abort_after: -1, poke: 0, exp_beats: 5, exp_done: 1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
